// File: rtl/lut_test_pkg.sv
// ============================================================================
// Module : lut_test_pkg
// Brief  : Shared types and helpers for the LUT test sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lut_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int unsigned c_max_inputs = 6;

    function automatic int unsigned vec_count(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut_test_sequencer_if.sv
// ============================================================================
// Module : lut_test_sequencer_if
// Brief  : Stimulus/response and result bundle of the LUT test sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lut_test_sequencer_if #(
    parameter int N_INPUTS  = 2,
    parameter int ERR_CNT_W = 8
);
    logic                  start;
    logic [N_INPUTS-1:0]   lut_in;
    logic                  lut_out;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ERR_CNT_W-1:0]  err_count;
    logic [N_INPUTS-1:0]   first_err_idx;
    logic                  first_err_valid;

    modport master (
        output start,
        input  lut_in,
        output lut_out,
        input  busy, done, pass, err_count, first_err_idx, first_err_valid
    );

    modport slave (
        input  start,
        output lut_in,
        input  lut_out,
        output busy, done, pass, err_count, first_err_idx, first_err_valid
    );
endinterface

`default_nettype wire

// File: rtl/lut_test_sequencer_sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchronizer with asynchronous active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

`default_nettype wire

// File: rtl/lut_test_sequencer.sv
// ============================================================================
// Module : lut_test_sequencer
// Brief  : Walks all LUT input vectors, samples the synchronized response and
//          scores it against an expected truth table.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lut_test_sequencer
    import lut_test_pkg::*;
#(
    parameter int                      N_INPUTS      = 2,
    parameter logic [2**N_INPUTS-1:0]  TRUTH_TABLE   = 4'b1110,
    parameter int                      SETTLE_CYCLES = 3,
    parameter int                      ERR_CNT_W     = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    lut_test_sequencer_if.slave bus
);
    localparam int unsigned         c_num_vec  = vec_count(N_INPUTS);
    localparam logic [N_INPUTS:0]   c_last_idx = (N_INPUTS+1)'(c_num_vec - 1);
    localparam int                  c_cnt_w    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(SETTLE_CYCLES - 1);

    // Two synchronizer stages plus the sample cycle need at least 3 cycles.
    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("SETTLE_CYCLES must be >= 3");
        end
        if (N_INPUTS < 1 || N_INPUTS > c_max_inputs) begin : g_bad_inputs
            $error("N_INPUTS must be in 1..6");
        end
    endgenerate

    state_t                 r_state, w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [N_INPUTS:0]      r_idx;
    logic [N_INPUTS:0]      w_idx_inc;
    logic [N_INPUTS-1:0]    r_lut_in;
    logic                   r_busy, r_done, r_pass;
    logic [ERR_CNT_W-1:0]   r_err;
    logic [N_INPUTS-1:0]    r_first_idx;
    logic                   r_first_valid;
    logic                   w_sync_out;
    logic                   w_launch, w_sample, w_mismatch, w_advance, w_finish;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.lut_out),
        .o_q   (w_sync_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (bus.start) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_cnt == c_cnt_last) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: w_state_nxt = (r_idx == c_last_idx) ? ST_FINISH : ST_SETTLE;
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_launch   = (r_state == ST_IDLE) && bus.start;
        w_sample   = (r_state == ST_SAMPLE);
        w_mismatch = w_sample && (w_sync_out != TRUTH_TABLE[r_idx[N_INPUTS-1:0]]);
        w_advance  = w_sample && (r_idx != c_last_idx);
        w_finish   = (r_state == ST_FINISH);
        w_idx_inc  = r_idx + (N_INPUTS+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_lut_in      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err         <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= w_finish;

            if (w_launch) begin
                r_cnt         <= c_cnt_w'(1);
                r_idx         <= '0;
                r_lut_in      <= '0;
                r_err         <= '0;
                r_first_idx   <= '0;
                r_first_valid <= 1'b0;
                r_pass        <= 1'b0;
            end

            if (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE)
                r_cnt <= r_cnt + c_cnt_w'(1);

            if (w_mismatch) begin
                if (r_err != '1) r_err <= r_err + ERR_CNT_W'(1);
                if (!r_first_valid) begin
                    r_first_idx   <= r_idx[N_INPUTS-1:0];
                    r_first_valid <= 1'b1;
                end
            end

            // Next vector is presented on the same edge that leaves SAMPLE.
            if (w_advance) begin
                r_idx    <= w_idx_inc;
                r_lut_in <= w_idx_inc[N_INPUTS-1:0];
                r_cnt    <= c_cnt_w'(1);
            end

            if (w_finish) r_pass <= (r_err == '0);
        end
    end

    assign bus.lut_in          = r_lut_in;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_count       = r_err;
    assign bus.first_err_idx   = r_first_idx;
    assign bus.first_err_valid = r_first_valid;
endmodule

`default_nettype wire

// File: tb/tb_lut_test_sequencer.sv
// ============================================================================
// Module : tb_lut_test_sequencer
// Brief  : Directed self-checking bench for lut_test_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lut_test_sequencer;
    logic clk;
    logic rst_n;
    logic a_stuck;
    int   n_checks;
    int   n_pass;
    int   lat;
    logic [2:0] lut_seen  [0:63];
    logic       busy_seen [0:63];

    lut_test_sequencer_if #(.N_INPUTS(2), .ERR_CNT_W(8)) ifa ();
    lut_test_sequencer_if #(.N_INPUTS(2), .ERR_CNT_W(2)) ifb ();
    lut_test_sequencer_if #(.N_INPUTS(3), .ERR_CNT_W(8)) ifc ();

    // A: ideal OR or stuck-at-0, B: inverted OR, C: ideal XOR3.
    assign ifa.lut_out = a_stuck ? 1'b0 : |ifa.lut_in;
    assign ifb.lut_out = ~|ifb.lut_in;
    assign ifc.lut_out = ^ifc.lut_in;

    lut_test_sequencer #(.N_INPUTS(2), .TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(3), .ERR_CNT_W(8))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    lut_test_sequencer #(.N_INPUTS(2), .TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(3), .ERR_CNT_W(2))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    lut_test_sequencer #(.N_INPUTS(3), .TRUTH_TABLE(8'h96), .SETTLE_CYCLES(4), .ERR_CNT_W(8))
        u_dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       ifa.start = v;
            1:       ifb.start = v;
            default: ifc.start = v;
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            0:       return ifa.done;
            1:       return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    function automatic logic [2:0] get_lut_in(input int w);
        case (w)
            0:       return {1'b0, ifa.lut_in};
            1:       return {1'b0, ifb.lut_in};
            default: return ifc.lut_in;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return ifa.busy;
            1:       return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    // cyc = edges from the start-sampling edge until done is seen high.
    task automatic run(input int w, input bit repulse, output int cyc);
        @(negedge clk);
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        cyc = 0;
        lut_seen[0]  = get_lut_in(w);
        busy_seen[0] = get_busy(w);
        while (!get_done(w) && cyc < 100) begin
            if (repulse && cyc == 4) set_start(w, 1'b1);
            @(posedge clk);
            #1;
            cyc++;
            if (repulse && cyc == 5) set_start(w, 1'b0);
            if (cyc < 64) begin
                lut_seen[cyc]  = get_lut_in(w);
                busy_seen[cyc] = get_busy(w);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        a_stuck  = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(ifa.busy), 32'd0);
        chk("rst_done",   32'(ifa.done), 32'd0);
        chk("rst_pass",   32'(ifa.pass), 32'd0);
        chk("rst_err",    32'(ifa.err_count), 32'd0);
        chk("rst_fvalid", 32'(ifa.first_err_valid), 32'd0);
        chk("rst_lut_in", 32'(ifa.lut_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ideal OR: full clean run
        run(0, 1'b0, lat);
        chk("s1_latency", 32'(lat), 32'd13);
        chk("s1_busy0",   32'(busy_seen[0]), 32'd1);
        chk("s1_vec0",    32'(lut_seen[2]), 32'd0);
        chk("s1_vec1",    32'(lut_seen[3]), 32'd1);
        chk("s1_vec2",    32'(lut_seen[6]), 32'd2);
        chk("s1_vec3a",   32'(lut_seen[9]), 32'd3);
        chk("s1_vec3b",   32'(lut_seen[11]), 32'd3);
        chk("s1_pass",    32'(ifa.pass), 32'd1);
        chk("s1_err",     32'(ifa.err_count), 32'd0);
        chk("s1_fvalid",  32'(ifa.first_err_valid), 32'd0);
        chk("s1_busy_end", 32'(ifa.busy), 32'd0);
        @(posedge clk);
        #1;
        chk("s1_done_pulse", 32'(ifa.done), 32'd0);
        chk("s1_lut_hold",   32'(ifa.lut_in), 32'd3);
        chk("s1_pass_hold",  32'(ifa.pass), 32'd1);

        // Stuck-at-0 output
        a_stuck = 1'b1;
        run(0, 1'b0, lat);
        chk("s2_latency", 32'(lat), 32'd13);
        chk("s2_err",     32'(ifa.err_count), 32'd3);
        chk("s2_fidx",    32'(ifa.first_err_idx), 32'd1);
        chk("s2_fvalid",  32'(ifa.first_err_valid), 32'd1);
        chk("s2_pass",    32'(ifa.pass), 32'd0);
        a_stuck = 1'b0;

        // Start re-pulsed mid-run is ignored
        run(0, 1'b1, lat);
        chk("s4_latency", 32'(lat), 32'd13);
        chk("s4_pass",    32'(ifa.pass), 32'd1);
        chk("s4_err",     32'(ifa.err_count), 32'd0);
        chk("s4_fvalid",  32'(ifa.first_err_valid), 32'd0);

        // Reset asserted mid-run
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("s5_pre_lut", 32'(ifa.lut_in), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_busy", 32'(ifa.busy), 32'd0);
        chk("s5_rst_lut",  32'(ifa.lut_in), 32'd0);
        chk("s5_rst_err",  32'(ifa.err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 1'b0, lat);
        chk("s5_latency", 32'(lat), 32'd13);
        chk("s5_pass",    32'(ifa.pass), 32'd1);

        // Inverted model, 2-bit saturating counter
        run(1, 1'b0, lat);
        chk("s3_latency", 32'(lat), 32'd13);
        chk("s3_err_sat", 32'(ifb.err_count), 32'd3);
        chk("s3_fidx",    32'(ifb.first_err_idx), 32'd0);
        chk("s3_fvalid",  32'(ifb.first_err_valid), 32'd1);
        chk("s3_pass",    32'(ifb.pass), 32'd0);

        // XOR3, 8 vectors, settle 4
        run(2, 1'b0, lat);
        chk("s6_latency", 32'(lat), 32'd33);
        chk("s6_vec1",    32'(lut_seen[4]), 32'd1);
        chk("s6_vec7",    32'(lut_seen[28]), 32'd7);
        chk("s6_pass",    32'(ifc.pass), 32'd1);
        chk("s6_err",     32'(ifc.err_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/lut_test_sequencer.md
Name: lut_test_sequencer

Overview:
Self-checking stimulus controller for a LUT under test placed between IB input buffers and an OB output buffer.
- Walks every input combination of an N-input LUT.
- Waits a programmable settle time for each vector, then samples the LUT output through a 2-flop synchronizer.
- Compares each sample against an expected truth table and reports pass/fail, error count and first failing index.
- Sits at the hardware-test top level; drives the IB-side nets and observes the OB-side net.

Parameters:
- N_INPUTS, 2, LUT input count; legal range 1..6.
- TRUTH_TABLE, 4'b1110 (2-input OR), expected output; bit i is the expected value for input vector i; width 2**N_INPUTS.
- SETTLE_CYCLES, 3, cycles each vector is held before sampling; must be >= 3 to cover synchronizer latency (elaboration error otherwise).
- ERR_CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- start  in  1  level; sampled only in IDLE.
- lut_in  out  N_INPUTS  stimulus vector to the LUT inputs.
- lut_out  in  1  LUT response; asynchronous to the sequencer and passed through the synchronizer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  result of last completed run; held until the next start.
- err_count  out  ERR_CNT_W  mismatches in the current or last run; saturates at all-ones.
- first_err_idx  out  N_INPUTS  vector index of the first mismatch.
- first_err_valid  out  1  first_err_idx is meaningful.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, synchronizer flops 0, idx=0, settle counter 0.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - start=1 at edge k -> SETTLE at k.
  - At the same edge: idx=0, lut_in=0, err_count=0, first_err_valid=0, first_err_idx=0, pass=0, busy=1.
  - start=0 -> stay in IDLE.
- SETTLE: lut_in=idx; counter counts 1..SETTLE_CYCLES-1, then -> SAMPLE.
- SAMPLE (one cycle): compare synchronized lut_out with TRUTH_TABLE[idx].
  - Mismatch: err_count += 1, saturating.
  - Mismatch and first_err_valid=0: first_err_idx=idx, first_err_valid=1.
  - idx = 2**N_INPUTS-1 -> FINISH.
  - Otherwise idx += 1 -> SETTLE, with lut_in updated at the same edge.
- Vector timing: each vector occupies exactly SETTLE_CYCLES cycles (SETTLE_CYCLES-1 in SETTLE, 1 in SAMPLE).
- FINISH (one cycle):
  - done=1, busy=0 at the next edge.
  - pass = (err_count==0), including the last sample's result.
  - -> IDLE.
- Run latency: start edge to done-high = 2**N_INPUTS*SETTLE_CYCLES + 1 cycles.
- lut_in holds its last vector after FINISH, until the next start.
- start while busy: ignored, no restart.
- start held high through FINISH: a new run begins on the first IDLE cycle, with no gap beyond the one IDLE cycle.
- idx counter is N_INPUTS+1 bits internally; no wrap into a second pass.
- Reset mid-run: immediate return to IDLE with reset values; partial results are discarded.
- err_count saturation: stays at 2**ERR_CNT_W-1; pass is still 0.

Decomposition:
- Package lut_test_pkg: state enum (IDLE, SETTLE, SAMPLE, FINISH) and the function that computes vector count from N_INPUTS.
- Sub-module sync_2ff: 2-flop synchronizer with async active-low reset, reused for other pad-observed nets.

Test Plan:
1. Defaults, ideal OR model on lut_in -> lut_out, start pulse -> lut_in 0,1,2,3, each held 3 cycles; done at cycle 13; pass=1, err_count=0, first_err_valid=0.
2. lut_out stuck at 0 -> err_count=3, first_err_idx=1, first_err_valid=1, pass=0.
3. Model output inverted, ERR_CNT_W=2 -> 4 mismatches, err_count saturates at 3, first_err_idx=0, pass=0.
4. start re-pulsed at cycle 5 of a run -> ignored; done still at cycle 13; results identical to scenario 1.
5. rst_n low at cycle 7 mid-run -> all outputs 0 immediately; a new start after release gives a clean full run with done 13 cycles later.
6. N_INPUTS=3, TRUTH_TABLE=8'h96 (XOR3), ideal model, SETTLE_CYCLES=4 -> 8 vectors, done at cycle 33, pass=1.
